axi_lite_dsc_slave: RTL and testbench
=====================================

// Module: axi_lite_dsc_slave
// PURPOSE
//  AXI-Lite responder that terminates descriptor writes and completion reads from the host-side AXI-Lite initiator.
//  Holds WRITEREG_NUMBER 32-bit descriptor registers at 0x00.. and presents the assembled descriptor to the engine.
//  Captures READREG_NUMBER engine completion words into status registers at READ_BASE_ADDR and raises irq.
//  Sits between the AXI-Lite interconnect and an action engine.
// PARAMETERS
//  LITE_DWIDTH     32     AXI-Lite data width; only 32 supported
//  LITE_AWIDTH     32     AXI-Lite address width
//  DSC_WIDTH       1024   descriptor width; must be >= WRITEREG_NUMBER*32
//  WRITEREG_NUMBER 14     number of descriptor registers, word addresses 0x00..(N-1)*4
//  READREG_NUMBER  1      number of status registers
//  READ_BASE_ADDR  'h100  byte address of status register 0
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              asynchronous, active-low reset
//  s_axi_aw{valid,ready,addr,prot}  in/out/in/in  1/1/AW/3  write address; prot ignored
//  s_axi_w{valid,ready,data,strb}   in/out/in/in  1/1/32/4  write data
//  s_axi_b{valid,ready,resp}        out/in/out    1/1/2     write response
//  s_axi_ar{valid,ready,addr,prot}  in/out/in/in  1/1/AW/3  read address; prot ignored
//  s_axi_r{valid,ready,data,resp}   out/in/out/out 1/1/32/2 read data
//  dsc_valid      out  1              descriptor available to engine
//  dsc_ready      in   1              engine takes descriptor
//  dsc_data       out  DSC_WIDTH      reg i at [32i+31:32i]; bits above WRITEREG_NUMBER*32 tie to 0
//  cpl_valid      in   1              engine completion valid
//  cpl_ready      out  1              status buffer free (= !irq)
//  cpl_data       in   READREG_NUMBER*32  completion words, word j -> status reg j
//  irq            out  1              completion pending, level
// BEHAVIOUR
//  Reset: all registers, bvalid, rvalid, dsc_valid, irq = 0; bresp/rresp/rdata = 0.
//   awready/wready/arready = 0 in reset and first cycle after release (registered out_of_reset flag).
//  Write path: AW and W are latched independently in any order, one of each held.
//   awready = oor & !aw_held & !bvalid & !dsc_valid; wready = same with w_held.
//   Cycle after both are held: register write, bvalid=1, hold flags cleared.
//   bvalid holds until bready.
//  Decode uses addr[AW-1:2]; addr[1:0] ignored.
//   Descriptor range: byte-lane write per wstrb, bresp=OKAY(00).
//   Any other address, including the status range: no write, bresp=SLVERR(10).
//  dsc_valid rises the cycle after the write to reg WRITEREG_NUMBER-1 commits; data includes that write.
//   dsc_valid is cleared on dsc_valid & dsc_ready.
//   While dsc_valid=1, awready and wready stay 0, so dsc_data is stable.
//  Read path: arready = oor & !rvalid. An AR handshake in cycle N gives rvalid=1 in cycle N+1 with registered rdata/rresp.
//   rvalid, rdata and rresp are held stable until rready.
//   Descriptor range: current register value, OKAY.
//   Status range READ_BASE_ADDR..+(READREG_NUMBER-1)*4: captured word, OKAY.
//   Other addresses: rdata=0, SLVERR.
//  Completion: on cpl_valid & cpl_ready, capture cpl_data; irq=1 next cycle.
//   irq clears the cycle after the R handshake of the last status register; earlier status reads do not clear it.
//   While irq=1, cpl_ready=0 and new completions stall; no overwrite or loss.
//   If an R handshake on the last status register coincides with cpl_valid, capture occurs the cycle after irq clears.
//  Reset mid-transaction: pending B/R are dropped with no response; the initiator must also be reset.
// STRUCTURE
//  Package axi_lite_dsc_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, function in_range(addr, base, n).
//  Sub-module axi_lite_dsc_wr_join: AW/W latching, join and B generation; outputs wr_en, wr_idx, wr_data, wr_strb, wr_err.
//  Read mux, descriptor/status storage and irq logic in top.
// TESTING
//  1 AW-before-W writes of 0x1000_0000+i to 0x00..0x34 -> all bresp=00; dsc_valid=1 after last commit; dsc_data[31:0]=0x1000_0000, [447:416]=0x1000_000D, [1023:448]=0.
//  2 reg 0x04=0xFFFFFFFF; W(0x12345678, strb 4'b0011) 3 cycles before AW 0x04 -> read 0x04 returns 0xFFFF5678, OKAY.
//  3 write 0x40 -> bresp=10, no register changes; read 0x200 -> rresp=10, rdata=0.
//  4 cpl_valid with cpl_data=0xCAFEF00D -> irq=1 and cpl_ready=0 next cycle; read 0x100 -> 0xCAFEF00D, OKAY; irq=0 cycle after R handshake.
//  5 dsc_ready held 0 with dsc_valid=1, AW/W presented -> awready/wready=0 until dsc_ready=1 for 1 cycle, then write completes.
//  6 rready low 5 cycles -> rvalid/rdata stable, arready=0; then rst_n low -> rvalid, bvalid, irq, dsc_valid=0 at once; read 0x00 after reset returns 0.

Source files
------------

// File: rtl/axi_lite_dsc_pkg.sv
`default_nettype none
//==============================================================================
// Package : axi_lite_dsc_pkg
// Brief   : Shared response codes and address-window helper for the descriptor slave.
// Revision: 1.0 - initial release
//==============================================================================
package axi_lite_dsc_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // True when the 32-bit word holding addr lies in [base, base + n*4); byte offset ignored.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] n);
        logic [31:0] word;
        logic [31:0] base_word;
        word      = addr >> 2;
        base_word = base >> 2;
        return (word >= base_word) && ((word - base_word) < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_dsc_if.sv
`default_nettype none
//==============================================================================
// Interface : axi_lite_dsc_if
// Brief     : AXI-Lite bus bundle between the host initiator and the descriptor slave.
// Revision  : 1.0 - initial release
//==============================================================================
interface axi_lite_dsc_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [AWIDTH-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [AWIDTH-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DWIDTH-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb,    input wready,
        input  bvalid, bresp,           output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp,    output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb,    output wready,
        output bvalid, bresp,           input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp,    input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_dsc_wr_join.sv
`default_nettype none
//==============================================================================
// Module  : axi_lite_dsc_wr_join
// Brief   : Latches AW and W independently, joins them into one register write, issues B.
// Revision: 1.0 - initial release
//==============================================================================
module axi_lite_dsc_wr_join
    import axi_lite_dsc_pkg::*;
#(
    parameter int AWIDTH          = 32,
    parameter int WRITEREG_NUMBER = 14,
    parameter int IDX_W           = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              oor,
    input  logic              hold_off,
    input  logic              awvalid,
    output logic              awready,
    input  logic [AWIDTH-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              wr_err
);

    logic              r_aw_held;
    logic              r_w_held;
    logic [AWIDTH-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    // Neither channel is accepted while a response or an unconsumed descriptor is outstanding.
    assign awready = oor & ~r_aw_held & ~r_bvalid & ~hold_off;
    assign wready  = oor & ~r_w_held  & ~r_bvalid & ~hold_off;

    assign wr_en   = r_aw_held & r_w_held;
    assign wr_idx  = r_awaddr[IDX_W+1:2];
    assign wr_data = r_wdata;
    assign wr_strb = r_wstrb;
    assign wr_err  = ~in_range(32'(r_awaddr), 32'h0, 32'(WRITEREG_NUMBER));
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (wvalid && wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (wr_en) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_dsc_slave.sv
`default_nettype none
//==============================================================================
// Module  : axi_lite_dsc_slave
// Brief   : AXI-Lite target holding descriptor registers and engine completion status.
// Revision: 1.0 - initial release
//==============================================================================
module axi_lite_dsc_slave
    import axi_lite_dsc_pkg::*;
#(
    parameter int          LITE_DWIDTH     = 32,
    parameter int          LITE_AWIDTH     = 32,
    parameter int          DSC_WIDTH       = 1024,
    parameter int          WRITEREG_NUMBER = 14,
    parameter int          READREG_NUMBER  = 1,
    parameter logic [31:0] READ_BASE_ADDR  = 32'h100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi_lite_dsc_if.slave                s_axi,
    output logic                         dsc_valid,
    input  logic                         dsc_ready,
    output logic [DSC_WIDTH-1:0]         dsc_data,
    input  logic                         cpl_valid,
    output logic                         cpl_ready,
    input  logic [READREG_NUMBER*32-1:0] cpl_data,
    output logic                         irq
);

    localparam int c_idx_w = (WRITEREG_NUMBER > 1) ? $clog2(WRITEREG_NUMBER) : 1;

    logic               r_oor;
    logic [31:0]        r_dsc    [WRITEREG_NUMBER];
    logic [31:0]        r_status [READREG_NUMBER];
    logic               r_dsc_valid;
    logic               r_irq;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic               r_rd_last;

    logic               w_wr_en;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [31:0]        w_wr_data;
    logic [3:0]         w_wr_strb;
    logic               w_wr_err;
    logic               w_wr_commit;
    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_cpl_hs;
    logic [31:0]        w_ar_addr;
    logic [31:0]        w_ar_word;
    logic [31:0]        w_rd_data;
    logic [1:0]         w_rd_resp;
    logic               w_rd_last;
    logic               w_unused_prot;

    assign w_unused_prot = ^{s_axi.awprot, s_axi.arprot};

    axi_lite_dsc_wr_join #(
        .AWIDTH          (LITE_AWIDTH),
        .WRITEREG_NUMBER (WRITEREG_NUMBER),
        .IDX_W           (c_idx_w)
    ) u_wr_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .oor      (r_oor),
        .hold_off (r_dsc_valid),
        .awvalid  (s_axi.awvalid),
        .awready  (s_axi.awready),
        .awaddr   (s_axi.awaddr),
        .wvalid   (s_axi.wvalid),
        .wready   (s_axi.wready),
        .wdata    (s_axi.wdata),
        .wstrb    (s_axi.wstrb),
        .bvalid   (s_axi.bvalid),
        .bready   (s_axi.bready),
        .bresp    (s_axi.bresp),
        .wr_en    (w_wr_en),
        .wr_idx   (w_wr_idx),
        .wr_data  (w_wr_data),
        .wr_strb  (w_wr_strb),
        .wr_err   (w_wr_err)
    );

    assign w_wr_commit = w_wr_en & ~w_wr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oor <= 1'b0;
            for (int i = 0; i < WRITEREG_NUMBER; i++) r_dsc[i] <= '0;
        end else begin
            r_oor <= 1'b1;
            if (w_wr_commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_strb[b]) r_dsc[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Writing the last register publishes the descriptor; it stays frozen until the engine takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dsc_valid <= 1'b0;
        end else if (w_wr_commit && (w_wr_idx == c_idx_w'(WRITEREG_NUMBER - 1))) begin
            r_dsc_valid <= 1'b1;
        end else if (r_dsc_valid && dsc_ready) begin
            r_dsc_valid <= 1'b0;
        end
    end

    assign dsc_valid = r_dsc_valid;

    for (genvar gi = 0; gi < WRITEREG_NUMBER; gi++) begin : g_pack
        assign dsc_data[32*gi +: 32] = r_dsc[gi];
    end
    if (DSC_WIDTH > WRITEREG_NUMBER*32) begin : g_pad
        assign dsc_data[DSC_WIDTH-1:WRITEREG_NUMBER*32] = '0;
    end

    assign s_axi.arready = r_oor & ~r_rvalid;
    assign w_ar_hs       = s_axi.arvalid & s_axi.arready;
    assign w_r_hs        = r_rvalid & s_axi.rready;
    assign w_ar_addr     = 32'(s_axi.araddr);
    assign w_ar_word     = w_ar_addr >> 2;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        w_rd_last = 1'b0;
        if (in_range(w_ar_addr, 32'h0, 32'(WRITEREG_NUMBER))) begin
            w_rd_resp = RESP_OKAY;
            for (int i = 0; i < WRITEREG_NUMBER; i++) begin
                if (w_ar_word == 32'(i)) w_rd_data = r_dsc[i];
            end
        end else if (in_range(w_ar_addr, READ_BASE_ADDR, 32'(READREG_NUMBER))) begin
            w_rd_resp = RESP_OKAY;
            for (int j = 0; j < READREG_NUMBER; j++) begin
                if (w_ar_word == (READ_BASE_ADDR >> 2) + 32'(j)) w_rd_data = r_status[j];
            end
            w_rd_last = (w_ar_word == (READ_BASE_ADDR >> 2) + 32'(READREG_NUMBER - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rd_last <= 1'b0;
        end else if (w_ar_hs) begin
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_rd_last <= w_rd_last;
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi.rvalid = r_rvalid;
    assign s_axi.rdata  = r_rdata;
    assign s_axi.rresp  = r_rresp;

    // Status buffer is single-entry: a new completion waits until the host has read the last word.
    assign cpl_ready = ~r_irq;
    assign w_cpl_hs  = cpl_valid & ~r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
            for (int j = 0; j < READREG_NUMBER; j++) r_status[j] <= '0;
        end else if (w_cpl_hs) begin
            r_irq <= 1'b1;
            for (int j = 0; j < READREG_NUMBER; j++) r_status[j] <= cpl_data[32*j +: 32];
        end else if (w_r_hs && r_rd_last) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_dsc_slave.sv
`default_nettype none
//==============================================================================
// Module  : tb_axi_lite_dsc_slave
// Brief   : Directed scoreboard bench for the AXI-Lite descriptor slave.
// Revision: 1.0 - initial release
//==============================================================================
module tb_axi_lite_dsc_slave;
    import axi_lite_dsc_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dsc_valid;
    logic          dsc_ready;
    logic [1023:0] dsc_data;
    logic          cpl_valid;
    logic          cpl_ready;
    logic [31:0]   cpl_data;
    logic          irq;

    always #5 clk = ~clk;

    axi_lite_dsc_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    axi_lite_dsc_slave #(
        .LITE_DWIDTH(32), .LITE_AWIDTH(32), .DSC_WIDTH(1024),
        .WRITEREG_NUMBER(14), .READREG_NUMBER(1), .READ_BASE_ADDR(32'h100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(bus),
        .dsc_valid(dsc_valid), .dsc_ready(dsc_ready), .dsc_data(dsc_data),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data),
        .irq(irq)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  exp_b[$];
    r_exp_t      exp_r[$];
    logic [1:0]  mon_b;
    r_exp_t      mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Response monitor: pops the scoreboard whenever a response handshake is about to happen.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) fail_now("b_unexpected");
                else begin
                    mon_b = exp_b.pop_front();
                    check("bresp", 64'(bus.bresp), 64'(mon_b));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) fail_now("r_unexpected");
                else begin
                    mon_r = exp_r.pop_front();
                    check("rdata", 64'(bus.rdata), 64'(mon_r.data));
                    check("rresp", 64'(bus.rresp), 64'(mon_r.resp));
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input int aw_lag, input int w_lag);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_go;
        bit w_go;
        int c = 0;
        exp_b.push_back(resp);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && c < 200) begin
            if (!aw_done && c >= aw_lag) bus.awvalid = 1'b1;
            if (!w_done && c >= w_lag)   bus.wvalid  = 1'b1;
            @(negedge clk);
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            @(posedge clk);
            #1;
            if (aw_go) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) fail_now("write_handshake_timeout");
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        r_exp_t e;
        bit go;
        bit done = 0;
        int c = 0;
        e.data = data;
        e.resp = resp;
        exp_r.push_back(e);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!done && c < 200) begin
            @(negedge clk);
            go = bus.arvalid && bus.arready;
            @(posedge clk);
            #1;
            if (go) begin bus.arvalid = 1'b0; done = 1; end
            c++;
        end
        bus.arvalid = 1'b0;
        if (!done) fail_now("read_handshake_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) fail_now("response_timeout");
    endtask

    task automatic cpl_pulse(input logic [31:0] data);
        cpl_data  = data;
        cpl_valid = 1'b1;
        @(posedge clk);
        #1;
        cpl_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 1;
        bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0;
        bus.rready  = 1;
        dsc_ready = 0; cpl_valid = 0; cpl_data = '0;

        // Reset state
        cycles(3);
        check("rst_bvalid", 64'(bus.bvalid), 0);
        check("rst_rvalid", 64'(bus.rvalid), 0);
        check("rst_dsc_valid", 64'(dsc_valid), 0);
        check("rst_irq", 64'(irq), 0);
        check("rst_cpl_ready", 64'(cpl_ready), 1);
        check("rst_awready", 64'(bus.awready), 0);
        check("rst_rdata", 64'(bus.rdata), 0);
        rst_n = 1'b1;
        #1;
        check("oor_awready", 64'(bus.awready), 0);
        check("oor_wready", 64'(bus.wready), 0);
        check("oor_arready", 64'(bus.arready), 0);
        cycles(1);
        check("ready_after_oor", 64'(bus.awready), 1);

        // 1: fill all descriptor registers, AW before W
        for (int i = 0; i < 14; i++) begin
            axi_write(32'(4*i), 32'h1000_0000 + 32'(i), 4'hF, RESP_OKAY, 0, 1);
            wait_idle();
            if (i == 12) check("dsc_valid_early", 64'(dsc_valid), 0);
        end
        check("dsc_valid_set", 64'(dsc_valid), 1);
        check("dsc_word0", 64'(dsc_data[31:0]), 64'h1000_0000);
        check("dsc_word13", 64'(dsc_data[447:416]), 64'h1000_000D);
        check("dsc_pad_zero", 64'(|dsc_data[1023:448]), 0);
        check("awready_blocked", 64'(bus.awready), 0);
        dsc_ready = 1'b1;
        cycles(1);
        dsc_ready = 1'b0;
        check("dsc_valid_clear", 64'(dsc_valid), 0);

        // 2: W ahead of AW with partial strobe
        axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, 0, 0);
        wait_idle();
        axi_write(32'h04, 32'h1234_5678, 4'b0011, RESP_OKAY, 3, 0);
        wait_idle();
        axi_read(32'h04, 32'hFFFF_5678, RESP_OKAY);
        wait_idle();

        // 3: decode errors and boundaries
        axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 0, 0);
        axi_write(32'h38, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 0, 0);
        axi_write(32'h100, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 0, 0);
        wait_idle();
        check("err_no_dsc_valid", 64'(dsc_valid), 0);
        axi_read(32'h04, 32'hFFFF_5678, RESP_OKAY);
        axi_read(32'h36, 32'h1000_000D, RESP_OKAY);
        axi_read(32'h200, 32'h0, RESP_SLVERR);
        axi_read(32'h104, 32'h0, RESP_SLVERR);
        axi_read(32'h100, 32'h0, RESP_OKAY);
        wait_idle();

        // 4: completion capture, stall and irq clear
        cpl_pulse(32'hCAFE_F00D);
        check("irq_set", 64'(irq), 1);
        check("cpl_ready_low", 64'(cpl_ready), 0);
        cpl_data  = 32'h1111_1111;
        cpl_valid = 1'b1;
        cycles(3);
        check("irq_held", 64'(irq), 1);
        axi_read(32'h100, 32'hCAFE_F00D, RESP_OKAY);
        cycles(1);
        check("irq_clear", 64'(irq), 0);
        check("cpl_ready_high", 64'(cpl_ready), 1);
        cycles(1);
        check("irq_recapture", 64'(irq), 1);
        cpl_valid = 1'b0;
        axi_read(32'h100, 32'h1111_1111, RESP_OKAY);
        wait_idle();
        check("irq_clear2", 64'(irq), 0);

        // 5: writes stall while the descriptor is pending
        axi_write(32'h34, 32'h5555_AAAA, 4'hF, RESP_OKAY, 0, 0);
        wait_idle();
        check("dsc_valid_again", 64'(dsc_valid), 1);
        check("dsc_word13_new", 64'(dsc_data[447:416]), 64'h5555_AAAA);
        fork
            axi_write(32'h00, 32'hA5A5_A5A5, 4'hF, RESP_OKAY, 0, 0);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("stall_awready", 64'(bus.awready), 0);
                    check("stall_wready", 64'(bus.wready), 0);
                end
                check("stall_dsc_stable", 64'(dsc_data[31:0]), 64'h1000_0000);
                @(posedge clk);
                #1;
                dsc_ready = 1'b1;
                cycles(1);
                dsc_ready = 1'b0;
            end
        join
        wait_idle();
        check("dsc_valid_released", 64'(dsc_valid), 0);
        axi_read(32'h00, 32'hA5A5_A5A5, RESP_OKAY);
        wait_idle();

        // 6: back-pressured R, then reset mid-transaction
        bus.bready = 1'b0;
        axi_write(32'h34, 32'h7777_7777, 4'hF, RESP_OKAY, 0, 0);
        cycles(2);
        check("pend_bvalid", 64'(bus.bvalid), 1);
        check("pend_dsc_valid", 64'(dsc_valid), 1);
        cpl_pulse(32'h2222_2222);
        check("pend_irq", 64'(irq), 1);
        bus.rready = 1'b0;
        axi_read(32'h00, 32'hA5A5_A5A5, RESP_OKAY);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rvalid", 64'(bus.rvalid), 1);
            check("hold_rdata", 64'(bus.rdata), 64'hA5A5_A5A5);
            check("hold_arready", 64'(bus.arready), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 64'(bus.rvalid), 0);
        check("arst_bvalid", 64'(bus.bvalid), 0);
        check("arst_irq", 64'(irq), 0);
        check("arst_dsc_valid", 64'(dsc_valid), 0);
        exp_b.delete();
        exp_r.delete();
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        #1;
        check("arst_oor_arready", 64'(bus.arready), 0);
        axi_read(32'h00, 32'h0, RESP_OKAY);
        axi_read(32'h100, 32'h0, RESP_OKAY);
        wait_idle();
        check("arst_dsc_word0", 64'(dsc_data[31:0]), 0);

        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
